sort_ctrl: RTL

Sequential sorting controller built around one shared magnitude comparator. Accepts a burst of DEPTH unsigned words over a valid/ready input stream and sorts them in place ascending, one compare-and-swap per cycle. It then streams the sorted words out over a valid/ready output stream. The comparator datapath becomes a time-multiplexed resource, sequenced by this block's FSM.

---
 rtl/sort_pkg.sv | 14 +
 rtl/sort_cmp_unit.sv | 16 +
 rtl/sort_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/sort_pkg.sv
// Shared types and sizing helpers for the sequential sort controller.
package sort_pkg;

  typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_t;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_DEPTH = 4;

  // Index width for a DEPTH-entry array; never narrower than one bit.
  function automatic int cntWidth(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sort_cmp_unit.sv
// Unsigned magnitude comparator, shared by every compare step of the sorter.
module cmp_unit #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             agb,
  output logic             aeb,
  output logic             alb
);

  assign agb = (a > b);
  assign aeb = (a == b);
  assign alb = (a < b);

endmodule

// File: rtl/sort_ctrl.sv
// Burst sorter: loads DEPTH words, bubble-sorts them in place with one shared
// comparator (one compare-and-swap per cycle), then streams them out ascending.
module sort_ctrl
  import sort_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy
);

  localparam int PTR_W = cntWidth(DEPTH);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] LAST_CMP = PTR_W'(DEPTH - 2);

  state_t           r_state;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_j;
  logic [PTR_W-1:0] r_rdPtr;
  logic [PTR_W-1:0] r_pass;
  logic             r_inReady;
  logic             r_outValid;
  logic             r_busy;

  logic [PTR_W-1:0] w_jNext;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic             w_agb;
  logic             w_aeb;
  logic             w_alb;
  logic             w_swap;

  assign w_jNext = r_j + PTR_W'(1);
  assign w_a     = r_mem[r_j];
  assign w_b     = r_mem[w_jNext];

  cmp_unit #(.WIDTH(WIDTH)) u_cmp (
    .a   (w_a),
    .b   (w_b),
    .agb (w_agb),
    .aeb (w_aeb),
    .alb (w_alb)
  );

  // Swap only on strictly greater, so equal keys keep their load order.
  assign w_swap = w_agb & ~(w_aeb | w_alb);

  assign in_ready  = r_inReady;
  assign busy      = r_busy;
  assign out_valid = r_outValid;
  assign out_last  = r_outValid & (r_rdPtr == LAST_IDX);
  assign out_data  = r_outValid ? r_mem[r_rdPtr] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= LOAD;
      r_wrPtr    <= '0;
      r_j        <= '0;
      r_rdPtr    <= '0;
      r_pass     <= '0;
      r_inReady  <= 1'b1;
      r_outValid <= 1'b0;
      r_busy     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      case (r_state)
        LOAD: begin
          if (in_valid) begin
            r_mem[r_wrPtr] <= in_data;
            if (r_wrPtr == LAST_IDX) begin
              r_wrPtr   <= '0;
              r_j       <= '0;
              r_pass    <= '0;
              r_state   <= SORT;
              r_inReady <= 1'b0;
              r_busy    <= 1'b1;
            end else begin
              r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
          end
        end
        // Fixed (DEPTH-1)^2 compares, no early exit, so latency is data independent.
        SORT: begin
          if (w_swap) begin
            r_mem[r_j]     <= w_b;
            r_mem[w_jNext] <= w_a;
          end
          if (r_j == LAST_CMP) begin
            r_j <= '0;
            if (r_pass == LAST_CMP) begin
              r_state    <= DRAIN;
              r_busy     <= 1'b0;
              r_outValid <= 1'b1;
              r_rdPtr    <= '0;
            end else begin
              r_pass <= r_pass + PTR_W'(1);
            end
          end else begin
            r_j <= w_jNext;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (r_rdPtr == LAST_IDX) begin
              r_state    <= LOAD;
              r_outValid <= 1'b0;
              r_inReady  <= 1'b1;
              r_rdPtr    <= '0;
            end else begin
              r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
          end
        end
        default: r_state <= LOAD;
      endcase
    end
  end

endmodule
